// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared types and constants for the matrix encoder sequencer:
//                sequencer state encoding, error codes, step identifiers and
//                the geometry of the shared state memory.
//  Revision    : 1.0  initial release
// ============================================================================
package encoder_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FIN    = 3'd4,
        ST_ERR    = 3'd5
    } seq_state_t;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_SPURIOUS = 2'b10;

    // Step unit identifiers, in execution order
    localparam int STEP_COLPARITY = 0;
    localparam int STEP_ROTATE    = 1;
    localparam int STEP_PERMUTE   = 2;
    localparam int STEP_REVAL     = 3;
    localparam int STEP_ADDRC     = 4;

    // Shared state memory geometry
    localparam int LINES  = 64;
    localparam int LINE_W = 25;

endpackage
`default_nettype wire

// File: rtl/step_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : step_watchdog
//  Description : Per-step cycle watchdog. Counts cycles while enabled and
//                saturates at TIMEOUT-1. 'expire' is raised in the enabled
//                cycle in which the count steps onto TIMEOUT-1, so the owner
//                sees TIMEOUT-1 enabled cycles before reacting.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in   1   clock, rising edge
//    rst_n   in   1   asynchronous active-low reset
//    clear   in   1   zero the count (has priority over enable)
//    enable  in   1   count this cycle
//    expire  out  1   limit reached in this enabled cycle
// ============================================================================
module step_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Count is one below the limit: this enabled cycle lands on TIMEOUT-1.
    assign expire = enable && (r_count >= CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/encoder_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_step_sequencer
//  Description : Top-level sequencer for the matrix encoder. Runs the step
//                units in fixed order for NUM_ROUNDS rounds, granting the
//                shared state memory to one step at a time. Each step gets a
//                one-cycle start pulse and answers with a done pulse; a
//                watchdog flags a step that never answers.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   1          clock, rising edge
//    rst_n      in   1          asynchronous active-low reset
//    start      in   1          begin encode (accepted in IDLE or ERR)
//    abort      in   1          return to IDLE, overrides everything
//    step_done  in   NUM_STEPS  one-hot done pulse from step units
//    step_en    out  NUM_STEPS  one-hot start pulse to the selected step
//    mem_sel    out  SW         step owning the memory port
//    step_idx   out  SW         current step
//    round_idx  out  RW         current round
//    busy       out  1          encode in progress
//    done       out  1          one-cycle completion pulse
//    error      out  1          sticky error flag
//    err_code   out  2          01 timeout, 10 spurious done, 00 none
// ============================================================================
module encoder_step_sequencer
    import encoder_pkg::*;
#(
    parameter int NUM_STEPS  = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int TIMEOUT    = 4096,
    parameter int SW         = (NUM_STEPS  > 1) ? $clog2(NUM_STEPS)  : 1,
    parameter int RW         = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_STEPS-1:0] step_done,
    output logic [NUM_STEPS-1:0] step_en,
    output logic [SW-1:0]        mem_sel,
    output logic [SW-1:0]        step_idx,
    output logic [RW-1:0]        round_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);

    localparam logic [SW-1:0] LAST_STEP  = SW'(NUM_STEPS - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [SW-1:0]        r_step;
    logic [SW-1:0]        w_step_next;
    logic [RW-1:0]        r_round;
    logic [RW-1:0]        w_round_next;
    logic [SW-1:0]        r_mem_sel;
    logic                 r_error;
    logic                 w_error_next;
    logic [1:0]           r_err_code;
    logic [1:0]           w_err_code_next;
    logic [NUM_STEPS-1:0] w_step_mask;
    logic                 w_valid_done;
    logic                 w_spurious;
    logic                 w_wd_clear;
    logic                 w_wd_en;
    logic                 w_wd_expire;

    assign w_step_mask  = NUM_STEPS'(1) << r_step;
    assign w_valid_done = |(step_done & w_step_mask);
    assign w_spurious   = |(step_done & ~w_step_mask);

    assign w_wd_clear = (r_state == ST_LAUNCH);
    assign w_wd_en    = (r_state == ST_WAIT);

    step_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_wd_clear),
        .enable (w_wd_en),
        .expire (w_wd_expire)
    );

    // ------------------------------------------------------------------
    // State register and the registers that move with it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_round    <= '0;
            r_mem_sel  <= '0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_round    <= w_round_next;
            r_error    <= w_error_next;
            r_err_code <= w_err_code_next;
            // Memory ownership moves only on entry to LAUNCH, so it already
            // points at the new step in its launch cycle and never changes
            // while that step runs.
            if (w_state_next == ST_LAUNCH) begin
                r_mem_sel <= w_step_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_step_next     = r_step;
        w_round_next    = r_round;
        w_error_next    = r_error;
        w_err_code_next = r_err_code;

        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    w_state_next    = ST_LAUNCH;
                    w_step_next     = '0;
                    w_round_next    = '0;
                    w_error_next    = 1'b0;
                    w_err_code_next = ERR_NONE;
                end
            end
            ST_LAUNCH: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid done beats both a stray done and a watchdog expiry.
                if (w_valid_done) begin
                    w_state_next = ST_NEXT;
                end else if (w_spurious) begin
                    w_state_next    = ST_ERR;
                    w_error_next    = 1'b1;
                    w_err_code_next = ERR_SPURIOUS;
                end else if (w_wd_expire) begin
                    w_state_next    = ST_ERR;
                    w_error_next    = 1'b1;
                    w_err_code_next = ERR_TIMEOUT;
                end
            end
            ST_NEXT: begin
                if (r_step != LAST_STEP) begin
                    w_step_next  = r_step + SW'(1);
                    w_state_next = ST_LAUNCH;
                end else if (r_round != LAST_ROUND) begin
                    w_step_next  = '0;
                    w_round_next = r_round + RW'(1);
                    w_state_next = ST_LAUNCH;
                end else begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything: indices and error status are frozen.
        if (abort) begin
            w_state_next    = ST_IDLE;
            w_step_next     = r_step;
            w_round_next    = r_round;
            w_error_next    = r_error;
            w_err_code_next = r_err_code;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign step_en   = ((r_state == ST_LAUNCH) && !abort) ? w_step_mask : '0;
    assign mem_sel   = r_mem_sel;
    assign step_idx  = r_step;
    assign round_idx = r_round;
    assign busy      = (r_state == ST_LAUNCH) || (r_state == ST_WAIT) ||
                       (r_state == ST_NEXT);
    assign done      = (r_state == ST_FIN) && !abort;
    assign error     = r_error;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_encoder_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_step_sequencer
//  Description : Self-checking bench for encoder_step_sequencer. A timeline
//                model (linear step number, launch cycle, elapsed wait time)
//                predicts every output each cycle; directed literals pin the
//                headline latencies and error behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder_step_sequencer;

    localparam int NS    = 5;
    localparam int NR    = 2;
    localparam int TO    = 16;
    localparam int SW    = 3;
    localparam int RW    = 1;
    localparam int TOTAL = NS * NR;

    // Model modes
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;
    localparam int M_FIN  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NS-1:0] step_done = '0;
    logic [NS-1:0] step_en;
    logic [SW-1:0] mem_sel;
    logic [SW-1:0] step_idx;
    logic [RW-1:0] round_idx;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    encoder_step_sequencer #(
        .NUM_STEPS  (NS),
        .NUM_ROUNDS (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .step_done (step_done),
        .step_en   (step_en),
        .mem_sel   (mem_sel),
        .step_idx  (step_idx),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Timeline model
    int         m_mode;
    int         m_lin;      // linear step number 0..TOTAL-1
    int         m_launch;   // cycle in which the current step is launched
    bit         m_got;      // current step has answered
    bit         m_err;
    logic [1:0] m_code;
    int         m_sel;

    // Step-unit responder
    int            pend_cyc = -1;
    logic [NS-1:0] pend_val = '0;
    int            g_lat    = 3;
    int            g_never  = -1;
    int            g_spur   = -1;
    bit            g_rand   = 1'b0;

    // Observation logs
    int            en_cyc_q[$];
    logic [NS-1:0] en_val_q[$];
    int            en_rnd_q[$];
    int            done_cyc_q[$];
    int            err_cyc = -1;

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_lin    = 0;
        m_launch = -100;
        m_got    = 1'b0;
        m_err    = 1'b0;
        m_code   = 2'b00;
        m_sel    = 0;
    endfunction

    function automatic void model_advance(input logic st, input logic ab,
                                          input logic [NS-1:0] sd);
        if (ab) begin
            m_mode = M_IDLE;
            m_got  = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE, M_ERR: begin
                if (st) begin
                    m_mode   = M_RUN;
                    m_lin    = 0;
                    m_launch = cyc + 1;
                    m_got    = 1'b0;
                    m_err    = 1'b0;
                    m_code   = 2'b00;
                    m_sel    = 0;
                end
            end
            M_RUN: begin
                if (cyc == m_launch) begin
                    // launch cycle: answers not looked at
                end else if (m_got) begin
                    if (m_lin == TOTAL - 1) begin
                        m_mode = M_FIN;
                    end else begin
                        m_lin    = m_lin + 1;
                        m_launch = cyc + 1;
                        m_got    = 1'b0;
                        m_sel    = m_lin % NS;
                    end
                end else if (sd[m_lin % NS]) begin
                    m_got = 1'b1;
                end else if (sd != '0) begin
                    m_mode = M_ERR;
                    m_err  = 1'b1;
                    m_code = 2'b10;
                end else if (cyc - m_launch == TO - 1) begin
                    m_mode = M_ERR;
                    m_err  = 1'b1;
                    m_code = 2'b01;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    task automatic compare();
        logic [NS-1:0] e_en;
        logic [16:0]   got_v;
        logic [16:0]   exp_v;
        int            idx;
        int            lat;
        e_en = '0;
        if (m_mode == M_RUN && cyc == m_launch && !abort) e_en[m_lin % NS] = 1'b1;
        exp_v = {e_en, SW'(m_sel), SW'(m_lin % NS), RW'(m_lin / NS),
                 (m_mode == M_RUN), (m_mode == M_FIN && !abort), m_err, m_code};
        got_v = {step_en, mem_sel, step_idx, round_idx, busy, done, error, err_code};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare @%0d: got en=%b sel=%0d idx=%0d rnd=%0d busy=%b done=%b err=%b code=%b, expected en=%b sel=%0d idx=%0d rnd=%0d busy=%b done=%b err=%b code=%b",
                     cyc, step_en, mem_sel, step_idx, round_idx, busy, done, error, err_code,
                     exp_v[16:12], exp_v[11:9], exp_v[8:6], exp_v[5], exp_v[4], exp_v[3],
                     exp_v[2], exp_v[1:0]);
        end
        if (done === 1'b1) done_cyc_q.push_back(cyc);
        if (error === 1'b1 && err_cyc < 0) err_cyc = cyc;
        if (step_en != '0) begin
            en_cyc_q.push_back(cyc);
            en_val_q.push_back(step_en);
            en_rnd_q.push_back(int'(round_idx));
            idx = 0;
            for (int b = NS - 1; b >= 0; b--) if (step_en[b]) idx = b;
            lat = g_rand ? int'($urandom_range(1, TO - 1)) : g_lat;
            if (idx == g_never) begin
                pend_cyc = -1;
            end else begin
                pend_cyc = cyc + lat;
                pend_val = '0;
                if (idx == g_spur) pend_val[(idx + 1 + int'($urandom_range(0, NS - 2))) % NS] = 1'b1;
                else               pend_val[idx] = 1'b1;
            end
        end
    endtask

    task automatic run_cycle(input logic st, input logic ab);
        start     = st;
        abort     = ab;
        step_done = (pend_cyc == cyc) ? pend_val : '0;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_advance(st, ab, step_done);
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        en_cyc_q.delete();
        en_val_q.delete();
        en_rnd_q.delete();
        done_cyc_q.delete();
        err_cyc  = -1;
        pend_cyc = -1;
    endtask

    task automatic all_outputs_zero(input string name);
        chk(name, {step_en, mem_sel, step_idx, round_idx, busy, done, error, err_code}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "time limit");
    end

    initial begin
        int s;
        int en2;
        bit aborted;
        int abort_at;
        int seq [10] = '{1, 2, 4, 8, 16, 1, 2, 4, 8, 16};

        // ---------------- power-on reset
        model_reset();
        @(negedge clk);
        compare();
        all_outputs_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(0, 0);

        // ---------------- full encode, 3-cycle steps, start noise while busy
        clear_logs();
        g_lat = 3; g_never = -1; g_spur = -1; g_rand = 1'b0;
        s = cyc;
        run_cycle(1, 0);
        for (int i = 0; i < 55; i++) run_cycle((i < 45) && (i % 7 == 3), 0);
        chk("t2_done_count", done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) chk("t2_done_cycle", done_cyc_q[0] - s + 1, 52);
        chk("t2_en_count", en_val_q.size(), 10);
        if (en_cyc_q.size() > 0) chk("t2_first_en_latency", en_cyc_q[0] - s, 1);
        for (int i = 0; i < 10 && i < en_val_q.size(); i++) begin
            chk("t2_step_en_seq", en_val_q[i], seq[i]);
            chk("t2_round_seq", en_rnd_q[i], i / NS);
        end
        chk("t2_busy_after", busy, 0);

        // ---------------- valid done in the same cycle as watchdog expiry
        clear_logs();
        g_lat = TO - 1;
        s = cyc;
        run_cycle(1, 0);
        for (int i = 0; i < 175; i++) run_cycle(0, 0);
        chk("t6_done_count", done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) chk("t6_done_cycle", done_cyc_q[0] - s, 1 + TOTAL * (2 + TO - 1));
        chk("t6_no_error", err_cyc, -1);

        // ---------------- step 2 never answers -> timeout
        clear_logs();
        g_lat = 3; g_never = 2;
        run_cycle(1, 0);
        for (int i = 0; i < 80 && err_cyc < 0; i++) run_cycle(0, 0);
        en2 = -1000;
        foreach (en_val_q[i]) if (en_val_q[i] == 5'b00100) en2 = en_cyc_q[i];
        chk("t3_timeout_latency", err_cyc - en2, TO);
        chk("t3_err_code", err_code, 1);
        chk("t3_step_en_in_err", step_en, 0);
        run_cycle(0, 0);
        // restart from ERR
        clear_logs();
        g_never = -1;
        run_cycle(1, 0);
        chk("t3_restart_en", step_en, 1);
        chk("t3_restart_error", error, 0);
        chk("t3_restart_code", err_code, 0);
        chk("t3_restart_round", round_idx, 0);
        run_cycle(0, 1);              // abort in the launch cycle
        run_cycle(0, 0);
        chk("t3_abort_busy", busy, 0);

        // ---------------- wrong step answers during WAIT on step 1
        clear_logs();
        g_lat = 2; g_spur = 1;
        s = cyc;
        run_cycle(1, 0);
        for (int i = 0; i < 40 && err_cyc < 0; i++) run_cycle(0, 0);
        chk("t4_err_cycle", err_cyc - s, 8);
        chk("t4_err_code", err_code, 2);
        chk("t4_err_step", step_idx, 1);
        for (int i = 0; i < 4; i++) run_cycle(0, 0);
        chk("t4_step_en_held", step_en, 0);
        g_spur = -1;

        // ---------------- abort in WAIT of round 1, step 3
        clear_logs();
        g_lat = 3;
        aborted = 1'b0;
        run_cycle(1, 0);
        for (int i = 0; i < 100 && !aborted; i++) begin
            if (m_mode == M_RUN && m_lin == NS + 3 && cyc == m_launch + 1) begin
                run_cycle(0, 1);
                aborted = 1'b1;
            end else begin
                run_cycle(i % 5 == 2, 0);
            end
        end
        chk("t5_abort_reached", aborted, 1);
        chk("t5_busy", busy, 0);
        chk("t5_held_step", step_idx, 3);
        chk("t5_held_round", round_idx, 1);
        for (int i = 0; i < 5; i++) run_cycle(0, 0);
        chk("t5_no_done", done_cyc_q.size(), 0);
        chk("t5_no_error", error, 0);

        // ---------------- asynchronous reset in the middle of WAIT
        clear_logs();
        run_cycle(1, 0);
        run_cycle(0, 0);
        run_cycle(0, 0);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; step_done = '0; pend_cyc = -1;
        model_reset();
        #1;
        all_outputs_zero("t1_async_reset");
        @(negedge clk);
        compare();
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        run_cycle(0, 0);

        // ---------------- randomized encodes
        g_rand = 1'b1;
        for (int r = 0; r < 14; r++) begin
            clear_logs();
            g_never  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
            g_spur   = (g_never < 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 120)) : -1;
            run_cycle(1, 0);
            for (int i = 0; i < 400; i++) begin
                run_cycle($urandom_range(0, 9) == 0, i == abort_at);
                if (m_mode == M_IDLE || m_mode == M_ERR) break;
            end
            chk("rand_run_ended", busy, 0);
            run_cycle(0, 0);
            run_cycle(0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
